// File: rtl/ddr3_cmd_arbiter_pkg.sv
// Shared types and helpers for the DDR3 command arbiter: FSM state and
// direction encodings, plus the saturating run-counter increment.
package ddr3_cmd_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WR   = 2'd1,
        ST_RD   = 2'd2
    } state_t;

    typedef enum logic {
        DIR_RD = 1'b0,
        DIR_WR = 1'b1
    } dir_t;

    localparam int unsigned RUN_W   = 8;
    localparam logic [7:0]  RUN_SAT = 8'd255;

    function automatic logic [7:0] run_sat_inc(input logic [7:0] run);
        run_sat_inc = (run == RUN_SAT) ? RUN_SAT : run + 8'd1;
    endfunction

endpackage

// File: rtl/ddr3_arb_checker.sv
// Protocol checker (simulation only): a requester must hold its request until
// accepted. Present only when __icarus is defined.
`ifdef __icarus
module ddr3_arb_checker (
    input logic clock,
    input logic reset,
    input logic wr_store_i,
    input logic rd_fetch_i,
    input logic mem_store_o,
    input logic mem_fetch_o
);

    // Flag a requester that drops its request while its command is presented.
    always @(posedge clock) begin
        if (!reset && mem_store_o && !wr_store_i)
            $error("ddr3_cmd_arbiter: wr_store_i dropped before accept");
        if (!reset && mem_fetch_o && !rd_fetch_i)
            $error("ddr3_cmd_arbiter: rd_fetch_i dropped before accept");
    end

endmodule
`endif

// File: rtl/ddr3_arb_policy.sv
// Combinational grant decision: picks the direction to serve from the pending
// flags, the last served direction, its run length and the RAW hazard flag.
import ddr3_cmd_arbiter_pkg::*;

module ddr3_arb_policy #(
    parameter int unsigned RD_RUN_MAX = 8,
    parameter int unsigned WR_RUN_MAX = 4
) (
    input  logic       wr_pend_i,
    input  logic       rd_pend_i,
    input  dir_t       last_dir_i,
    input  logic [7:0] run_i,
    input  logic       hazard_i,
    output logic       grant_valid_o,
    output dir_t       grant_dir_o
);

    // Direction choice; a pending hazard forces the write ahead of the read.
    always_comb begin
        grant_valid_o = 1'b0;
        grant_dir_o   = DIR_RD;
        if (wr_pend_i && rd_pend_i) begin
            grant_valid_o = 1'b1;
            if (hazard_i) begin
                grant_dir_o = DIR_WR;
            end else if (last_dir_i == DIR_WR) begin
                grant_dir_o = (run_i < 8'(WR_RUN_MAX)) ? DIR_WR : DIR_RD;
            end else begin
                grant_dir_o = (run_i < 8'(RD_RUN_MAX)) ? DIR_RD : DIR_WR;
            end
        end else if (wr_pend_i) begin
            grant_valid_o = 1'b1;
            grant_dir_o   = DIR_WR;
        end else if (rd_pend_i) begin
            grant_valid_o = 1'b1;
            grant_dir_o   = DIR_RD;
        end else begin
            grant_valid_o = 1'b0;
            grant_dir_o   = DIR_RD;
        end
    end

endmodule

// File: rtl/ddr3_cmd_arbiter.sv
// Shares the DDR3 controller command port between the write and read paths.
// Optional RAW-hazard write priority is enabled with DDR3_ARB_RAW_HAZARD_EN.
import ddr3_cmd_arbiter_pkg::*;

module ddr3_cmd_arbiter #(
    parameter int unsigned ADDRS        = 32,
    parameter int unsigned AXI_ID_WIDTH = 4,
    parameter int unsigned RD_RUN_MAX   = 8,
    parameter int unsigned WR_RUN_MAX   = 4,
    parameter int unsigned ADDR_LSB     = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    wr_store_i,
    output logic                    wr_accept_o,
    input  logic [AXI_ID_WIDTH-1:0] wr_reqid_i,
    input  logic [ADDRS-1:0]        wr_addr_i,
    input  logic                    rd_fetch_i,
    output logic                    rd_accept_o,
    input  logic [AXI_ID_WIDTH-1:0] rd_reqid_i,
    input  logic [ADDRS-1:0]        rd_addr_i,
    output logic                    mem_store_o,
    output logic                    mem_fetch_o,
    input  logic                    mem_accept_i,
    output logic [AXI_ID_WIDTH-1:0] mem_req_id_o,
    output logic [ADDRS-1:0]        mem_addr_o
);

    state_t     state_r;
    dir_t       last_dir_r;
    logic [7:0] run_r;
    logic       hazard_s;
    logic       grant_valid_s;
    dir_t       grant_dir_s;

`ifdef DDR3_ARB_RAW_HAZARD_EN
    // Same chunk on both sides: the read must see the write's data.
    assign hazard_s = wr_store_i && rd_fetch_i &&
                      (wr_addr_i[ADDRS-1:ADDR_LSB] == rd_addr_i[ADDRS-1:ADDR_LSB]);
`else
    assign hazard_s = 1'b0;
`endif

    ddr3_arb_policy #(
        .RD_RUN_MAX (RD_RUN_MAX),
        .WR_RUN_MAX (WR_RUN_MAX)
    ) u_policy (
        .wr_pend_i     (wr_store_i),
        .rd_pend_i     (rd_fetch_i),
        .last_dir_i    (last_dir_r),
        .run_i         (run_r),
        .hazard_i      (hazard_s),
        .grant_valid_o (grant_valid_s),
        .grant_dir_o   (grant_dir_s)
    );

    assign wr_accept_o = mem_accept_i & mem_store_o;
    assign rd_accept_o = mem_accept_i & mem_fetch_o;

    // Command FSM: grant from IDLE, hold until accepted, always return to IDLE.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            mem_store_o  <= 1'b0;
            mem_fetch_o  <= 1'b0;
            mem_req_id_o <= '0;
            mem_addr_o   <= '0;
            last_dir_r   <= DIR_RD;
            run_r        <= 8'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (grant_valid_s) begin
                        if (grant_dir_s == DIR_WR) begin
                            state_r      <= ST_WR;
                            mem_store_o  <= 1'b1;
                            mem_req_id_o <= wr_reqid_i;
                            mem_addr_o   <= wr_addr_i;
                        end else begin
                            state_r      <= ST_RD;
                            mem_fetch_o  <= 1'b1;
                            mem_req_id_o <= rd_reqid_i;
                            mem_addr_o   <= rd_addr_i;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_WR: begin
                    if (mem_accept_i) begin
                        state_r     <= ST_IDLE;
                        mem_store_o <= 1'b0;
                        run_r       <= (last_dir_r == DIR_WR) ? run_sat_inc(run_r) : 8'd1;
                        last_dir_r  <= DIR_WR;
                    end else begin
                        state_r <= ST_WR;
                    end
                end
                ST_RD: begin
                    if (mem_accept_i) begin
                        state_r     <= ST_IDLE;
                        mem_fetch_o <= 1'b0;
                        run_r       <= (last_dir_r == DIR_RD) ? run_sat_inc(run_r) : 8'd1;
                        last_dir_r  <= DIR_RD;
                    end else begin
                        state_r <= ST_RD;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    mem_store_o <= 1'b0;
                    mem_fetch_o <= 1'b0;
                end
            endcase
        end
    end

`ifdef __icarus
    ddr3_arb_checker u_chk (
        .clock       (clock),
        .reset       (reset),
        .wr_store_i  (wr_store_i),
        .rd_fetch_i  (rd_fetch_i),
        .mem_store_o (mem_store_o),
        .mem_fetch_o (mem_fetch_o)
    );
`endif

endmodule
